// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round constants, GF(2^8) helpers
// and the ShiftRows byte map. Byte 0 of a block sits in bits [127:120].
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // Indexed by round number; entries 0 and 11..15 are never used by a valid round.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    // Output byte i (column i/4, row i%4) takes input byte SHIFT_ROWS_MAP[i].
    localparam int SHIFT_ROWS_MAP [16] = '{0, 5, 10, 15, 4, 9, 14, 3,
                                          8, 13, 2, 7, 12, 1, 6, 11};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box as a pure combinational lookup.
module aes_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/aes_encipher_iter.sv
// Iterative AES-128 encryption: one shared round datapath, round keys expanded
// on the fly, valid/ready handshakes on both sides.
module aes_encipher_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int DATA_W     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] plain_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cipher_out,
    output logic              busy
);

    if (NUM_ROUNDS != 10 || DATA_W != 128) begin : g_param_check
        $error("aes_encipher_iter supports only NUM_ROUNDS=10 and DATA_W=128");
    end

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    aes_state_e   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] data_q, data_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] cout_q, cout_d;
    logic         in_ready_q, out_valid_q, busy_q;

    logic [7:0]   sb_s [16];
    logic [7:0]   sr_s [16];
    logic [7:0]   mc_s [16];
    logic [31:0]  rot_s, subw_s, w4_s, w5_s, w6_s, w7_s;
    logic [127:0] next_rk_s, round_s;

    assign rot_s = {rk_q[23:0], rk_q[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox_k (.byte_i(rot_s[31-8*j -: 8]), .byte_o(subw_s[31-8*j -: 8]));
    end

    assign w4_s      = rk_q[127:96] ^ subw_s ^ {RCON[rnd_q], 24'h000000};
    assign w5_s      = rk_q[95:64] ^ w4_s;
    assign w6_s      = rk_q[63:32] ^ w5_s;
    assign w7_s      = rk_q[31:0]  ^ w6_s;
    assign next_rk_s = {w4_s, w5_s, w6_s, w7_s};

    for (genvar i = 0; i < 16; i++) begin : g_data_sbox
        aes_sbox u_sbox_d (.byte_i(data_q[127-8*i -: 8]), .byte_o(sb_s[i]));
        assign sr_s[i] = sb_s[SHIFT_ROWS_MAP[i]];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc_s[4*c+0] = mul2(sr_s[4*c]) ^ mul3(sr_s[4*c+1]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
        assign mc_s[4*c+1] = sr_s[4*c] ^ mul2(sr_s[4*c+1]) ^ mul3(sr_s[4*c+2]) ^ sr_s[4*c+3];
        assign mc_s[4*c+2] = sr_s[4*c] ^ sr_s[4*c+1] ^ mul2(sr_s[4*c+2]) ^ mul3(sr_s[4*c+3]);
        assign mc_s[4*c+3] = mul3(sr_s[4*c]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ mul2(sr_s[4*c+3]);
    end

    // The final round skips MixColumns.
    for (genvar i = 0; i < 16; i++) begin : g_round_out
        assign round_s[127-8*i -: 8] = ((rnd_q == LAST_RND) ? sr_s[i] : mc_s[i])
                                       ^ next_rk_s[127-8*i -: 8];
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        data_d  = data_q;
        rk_d    = rk_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ROUND;
                    data_d  = plain_in ^ key_in;
                    rk_d    = key_in;
                    rnd_d   = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUND: begin
                data_d = round_s;
                rk_d   = next_rk_s;
                if (rnd_q == LAST_RND) begin
                    state_d = DONE;
                    cout_d  = round_s;
                    rnd_d   = 4'd0;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                rnd_d   = 4'd0;
            end
        endcase
    end

    // State, datapath and decoded output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rnd_q       <= 4'd0;
            data_q      <= 128'd0;
            rk_q        <= 128'd0;
            cout_q      <= 128'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            data_q      <= data_d;
            rk_q        <= rk_d;
            cout_q      <= cout_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign cipher_out = cout_q;

endmodule
